// File: rtl/regbank_dump_reader.sv
// -----------------------------------------------------------------------------
// regbank_dump_reader
//
// Debug read-out engine for a register bank read port. A start request walks
// the index range [first_reg..last_reg]. Each index is driven onto readreg for
// one cycle, and the value the bank returns is captured. The engine then
// presents the captured value as an {index, data, last} beat on a valid/ready
// output. Typical uses are state dumps and end-of-test checks.
//
// Ports
//   clk        : single clock, all state updates on posedge
//   rst_n      : asynchronous active-low reset
//   start      : dump request, sampled only while idle
//   abort      : cancel a dump in progress (READ/HOLD only)
//   first_reg  : first index of the range, sampled with start
//   last_reg   : last index of the range (inclusive), sampled with start
//   readreg    : read address to the bank; the bank read is combinational
//   regdata    : bank read data for readreg
//   out_valid  : beat available on out_data/out_index/out_last
//   out_ready  : consumer ready
//   out_data   : captured register value
//   out_index  : register index of the current beat
//   out_last   : beat belongs to last_reg
//   busy       : high while walking (READ/HOLD)
//   done       : one-cycle pulse after the final beat is accepted
//   range_err  : one-cycle pulse when start arrives with first_reg > last_reg
//   dbg_state  : current FSM state (0=IDLE 1=READ 2=HOLD 3=DONE)
//
// Handshake: a beat transfers on a rising edge where out_valid && out_ready.
// While out_valid is high and out_ready is low, out_data, out_index and
// out_last hold their values. out_valid never drops without a transfer,
// except on abort or reset.
// -----------------------------------------------------------------------------
module regbank_dump_reader #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] first_reg,
  input  logic [ADDR_W-1:0] last_reg,
  output logic [ADDR_W-1:0] readreg,
  input  logic [DATA_W-1:0] regdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_index,
  output logic              out_last,
  output logic              busy,
  output logic              done,
  output logic              range_err,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_HOLD = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   cur_q, cur_d;
  logic [ADDR_W-1:0]   end_q, end_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [ADDR_W-1:0]   index_q, index_d;
  logic                last_q, last_d;
  logic                range_err_q, range_err_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cur_q       <= '0;
      end_q       <= '0;
      data_q      <= '0;
      index_q     <= '0;
      last_q      <= 1'b0;
      range_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_q       <= cur_d;
      end_q       <= end_d;
      data_q      <= data_d;
      index_q     <= index_d;
      last_q      <= last_d;
      range_err_q <= range_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cur_d       = cur_q;
    end_d       = end_q;
    data_d      = data_q;
    index_d     = index_q;
    last_d      = last_q;
    range_err_d = 1'b0;
    readreg     = '0;
    out_valid   = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (first_reg <= last_reg) begin
            cur_d   = first_reg;
            end_d   = last_reg;
            state_d = S_READ;
          end else begin
            range_err_d = 1'b1;
          end
        end
      end

      S_READ: begin
        busy    = 1'b1;
        readreg = cur_q;
        data_d  = regdata;
        index_d = cur_q;
        // The last flag is decided here. As a result, the walk stops at end_q and
        // cur_q is never incremented past it, so it cannot wrap.
        last_d  = (cur_q == end_q);
        state_d = abort ? S_IDLE : S_HOLD;
      end

      S_HOLD: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        // abort takes priority. A beat that transfers in the same cycle is
        // delivered, but nothing follows it and done does not pulse.
        if (abort) begin
          state_d = S_IDLE;
        end else if (out_ready) begin
          if (last_q) begin
            state_d = S_DONE;
          end else begin
            cur_d   = cur_q + 1'b1;
            state_d = S_READ;
          end
        end
      end

      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign out_data  = data_q;
  assign out_index = index_q;
  assign out_last  = last_q;
  assign range_err = range_err_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_regbank_dump_reader.sv
// -----------------------------------------------------------------------------
// tb_regbank_dump_reader
//
// Bench for regbank_dump_reader. A register bank array drives regdata
// combinationally. The expected beat list for a dump of [f..l] comes directly
// from the range: one beat per index, in ascending order, carrying the bank
// value and a last flag only on l. Observed beats are collected at the falling
// edge and compared in each scenario task.
// -----------------------------------------------------------------------------
module tb_regbank_dump_reader;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NREG   = 32;
  localparam int BW     = 1 + ADDR_W + DATA_W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic              start, abort, out_ready;
  logic [ADDR_W-1:0] first_reg, last_reg, readreg, out_index;
  logic [DATA_W-1:0] regdata, out_data;
  logic              out_valid, out_last, busy, done, range_err;
  logic [1:0]        dbg_state;

  logic [DATA_W-1:0] bank [NREG];
  assign regdata = (readreg == '0) ? '0 : bank[readreg];

  regbank_dump_reader #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .abort     (abort),
    .first_reg (first_reg),
    .last_reg  (last_reg),
    .readreg   (readreg),
    .regdata   (regdata),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_index (out_index),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done),
    .range_err (range_err),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int tests_run = 0;
  int fails     = 0;
  logic [BW-1:0] exp_q[$];
  logic [BW-1:0] obs_q[$];
  int            hs_cyc_q[$];
  int            done_cnt;
  int            stable_bad;

  // Reference model: a dump of [f..l] yields every index in order.
  task automatic build_exp(input int f, input int l);
    logic [DATA_W-1:0] d;
    logic [ADDR_W-1:0] a;
    logic              lst;
    exp_q.delete();
    for (int i = f; i <= l; i++) begin
      a   = i[ADDR_W-1:0];
      d   = (i == 0) ? '0 : bank[i[ADDR_W-1:0]];
      lst = (i == l);
      exp_q.push_back({lst, a, d});
    end
  endtask

  task automatic fill_bank_ramp();
    for (int i = 0; i < NREG; i++) bank[i] = 32'h1000 + DATA_W'(i);
  endtask

  task automatic fill_bank_random();
    for (int i = 0; i < NREG; i++) bank[i] = $urandom;
  endtask

  // ---------------- driver tasks ----------------
  // Pulses start across one rising edge. Returns at the falling edge of the
  // cycle that follows that edge (cycle N+1).
  task automatic do_start(input int f, input int l);
    @(negedge clk);
    first_reg = ADDR_W'(f);
    last_reg  = ADDR_W'(l);
    start     = 1'b1;
    @(negedge clk);
    start     = 1'b0;
  endtask

  // Acts as the consumer from the current falling edge until the engine is idle
  // again. stall < 0 means a random 0..2 stall cycles per beat.
  task automatic collect(input int stall, input int abort_after, input bit poke_start);
    int hs = 0;
    int wait_n = 0;
    int c = 0;
    int stall_n;
    bit held = 0;
    logic [BW-1:0] snap, cur;
    obs_q.delete();
    hs_cyc_q.delete();
    done_cnt   = 0;
    stable_bad = 0;
    stall_n = (stall < 0) ? int'($urandom_range(0, 2)) : stall;
    forever begin
      if (done) done_cnt++;
      if (!busy && !out_valid) break;
      if (c >= 400) begin
        tests_run++;
        fails++;
        $display("FAIL collect_timeout: still busy after %0d cycles, required idle", c);
        break;
      end
      cur = {out_last, out_index, out_data};
      if (out_valid) begin
        if (held && cur !== snap) stable_bad++;
        snap = cur;
        held = 1;
        if (wait_n < stall_n) begin
          out_ready = 1'b0;
          wait_n++;
        end else begin
          out_ready = 1'b1;
          obs_q.push_back(cur);
          hs_cyc_q.push_back(c);
          hs++;
          wait_n = 0;
          held = 0;
          stall_n = (stall < 0) ? int'($urandom_range(0, 2)) : stall;
          if (abort_after > 0 && hs == abort_after) abort = 1'b1;
        end
      end else begin
        out_ready = 1'($urandom_range(0, 1));
        held = 0;
      end
      start = poke_start && busy && ($urandom_range(0, 3) == 0);
      if (start) begin
        first_reg = ADDR_W'($urandom);
        last_reg  = ADDR_W'($urandom);
      end
      @(negedge clk);
      c++;
      abort = 1'b0;
    end
    out_ready = 1'b0;
    start     = 1'b0;
    @(negedge clk);
    if (done) done_cnt++;
  endtask

  // ---------------- scenario tasks ----------------
  task automatic test_reset();
    tests_run++; if (readreg !== '0)   begin fails++; $display("FAIL reset_readreg: got %h, expected 0", readreg); end
    tests_run++; if (out_valid !== 0)  begin fails++; $display("FAIL reset_out_valid: got %b, expected 0", out_valid); end
    tests_run++; if (out_data !== '0)  begin fails++; $display("FAIL reset_out_data: got %h, expected 0", out_data); end
    tests_run++; if (out_index !== '0) begin fails++; $display("FAIL reset_out_index: got %h, expected 0", out_index); end
    tests_run++; if (out_last !== 0)   begin fails++; $display("FAIL reset_out_last: got %b, expected 0", out_last); end
    tests_run++; if (busy !== 0)       begin fails++; $display("FAIL reset_busy: got %b, expected 0", busy); end
    tests_run++; if (done !== 0)       begin fails++; $display("FAIL reset_done: got %b, expected 0", done); end
    tests_run++; if (range_err !== 0)  begin fails++; $display("FAIL reset_range_err: got %b, expected 0", range_err); end
  endtask

  task automatic test_full_range();
    fill_bank_ramp();
    build_exp(0, 31);
    do_start(0, 31);
    collect(0, 0, 0);
    tests_run++;
    if (obs_q.size() != exp_q.size()) begin
      fails++; $display("FAIL full_count: got %0d beats, expected %0d", obs_q.size(), exp_q.size());
    end
    for (int k = 0; k < obs_q.size() && k < exp_q.size(); k++) begin
      tests_run++;
      if (obs_q[k] !== exp_q[k]) begin
        fails++; $display("FAIL full_beat%0d: got %h, expected %h", k, obs_q[k], exp_q[k]);
      end
    end
    for (int k = 1; k < hs_cyc_q.size(); k++) begin
      tests_run++;
      if (hs_cyc_q[k] - hs_cyc_q[k-1] != 2) begin
        fails++; $display("FAIL full_gap%0d: got %0d cycles, expected 2", k, hs_cyc_q[k] - hs_cyc_q[k-1]);
      end
    end
    tests_run++;
    if (done_cnt != 1) begin fails++; $display("FAIL full_done: got %0d pulses, expected 1", done_cnt); end
  endtask

  task automatic test_single();
    fill_bank_random();
    build_exp(5, 5);
    do_start(5, 5);
    tests_run++; if (readreg !== 5'd5) begin fails++; $display("FAIL single_readreg_n1: got %0d, expected 5", readreg); end
    tests_run++; if (out_valid !== 0)  begin fails++; $display("FAIL single_valid_n1: got %b, expected 0", out_valid); end
    tests_run++; if (busy !== 1)       begin fails++; $display("FAIL single_busy_n1: got %b, expected 1", busy); end
    collect(0, 0, 0);
    tests_run++;
    if (obs_q.size() != 1) begin fails++; $display("FAIL single_count: got %0d beats, expected 1", obs_q.size()); end
    if (obs_q.size() > 0) begin
      tests_run++;
      if (obs_q[0] !== exp_q[0]) begin fails++; $display("FAIL single_beat: got %h, expected %h", obs_q[0], exp_q[0]); end
      tests_run++;
      if (hs_cyc_q[0] != 1) begin fails++; $display("FAIL single_latency: valid at cycle N+%0d, expected N+2", hs_cyc_q[0] + 1); end
    end
    tests_run++;
    if (done_cnt != 1) begin fails++; $display("FAIL single_done: got %0d pulses, expected 1", done_cnt); end
  endtask

  task automatic test_stall();
    fill_bank_random();
    build_exp(2, 4);
    do_start(2, 4);
    collect(3, 0, 0);
    tests_run++;
    if (stable_bad != 0) begin fails++; $display("FAIL stall_stable: got %0d changes while stalled, expected 0", stable_bad); end
    tests_run++;
    if (obs_q.size() != 3) begin fails++; $display("FAIL stall_count: got %0d beats, expected 3", obs_q.size()); end
    for (int k = 0; k < obs_q.size() && k < exp_q.size(); k++) begin
      tests_run++;
      if (obs_q[k] !== exp_q[k]) begin fails++; $display("FAIL stall_beat%0d: got %h, expected %h", k, obs_q[k], exp_q[k]); end
    end
    tests_run++;
    if (done_cnt != 1) begin fails++; $display("FAIL stall_done: got %0d pulses, expected 1", done_cnt); end
  endtask

  task automatic test_range_err();
    int re_cnt = 0, bad_busy = 0, bad_valid = 0, bad_done = 0;
    do_start(9, 3);
    tests_run++; if (range_err !== 1) begin fails++; $display("FAIL rerr_pulse_n1: got %b, expected 1", range_err); end
    for (int k = 0; k < 6; k++) begin
      if (range_err) re_cnt++;
      if (busy) bad_busy++;
      if (out_valid) bad_valid++;
      if (done) bad_done++;
      @(negedge clk);
    end
    tests_run++; if (re_cnt != 1)    begin fails++; $display("FAIL rerr_count: got %0d pulses, expected 1", re_cnt); end
    tests_run++; if (bad_busy != 0)  begin fails++; $display("FAIL rerr_busy: got %0d busy cycles, expected 0", bad_busy); end
    tests_run++; if (bad_valid != 0) begin fails++; $display("FAIL rerr_valid: got %0d valid cycles, expected 0", bad_valid); end
    tests_run++; if (bad_done != 0)  begin fails++; $display("FAIL rerr_done: got %0d done cycles, expected 0", bad_done); end
  endtask

  task automatic test_abort();
    fill_bank_ramp();
    build_exp(0, 3);
    do_start(0, 31);
    collect(0, 4, 0);
    tests_run++;
    if (obs_q.size() != 4) begin fails++; $display("FAIL abort_count: got %0d beats, expected 4", obs_q.size()); end
    for (int k = 0; k < obs_q.size() && k < 4; k++) begin
      tests_run++;
      // The last flag is not part of the aborted beats' expectation (index 3 is not last_reg).
      if (obs_q[k] !== {1'b0, exp_q[k][BW-2:0]}) begin
        fails++; $display("FAIL abort_beat%0d: got %h, expected %h", k, obs_q[k], {1'b0, exp_q[k][BW-2:0]});
      end
    end
    tests_run++; if (done_cnt != 0)  begin fails++; $display("FAIL abort_done: got %0d pulses, expected 0", done_cnt); end
    tests_run++; if (dbg_state !== 0) begin fails++; $display("FAIL abort_state: got %0d, expected IDLE(0)", dbg_state); end
    // A fresh dump after the abort runs normally.
    build_exp(7, 9);
    do_start(7, 9);
    collect(0, 0, 0);
    tests_run++;
    if (obs_q.size() != 3) begin fails++; $display("FAIL abort_restart_count: got %0d beats, expected 3", obs_q.size()); end
    for (int k = 0; k < obs_q.size() && k < exp_q.size(); k++) begin
      tests_run++;
      if (obs_q[k] !== exp_q[k]) begin fails++; $display("FAIL abort_restart_beat%0d: got %h, expected %h", k, obs_q[k], exp_q[k]); end
    end
    tests_run++; if (done_cnt != 1) begin fails++; $display("FAIL abort_restart_done: got %0d pulses, expected 1", done_cnt); end
  endtask

  task automatic test_start_during_dump();
    int extra = 0;
    fill_bank_random();
    build_exp(10, 20);
    do_start(10, 20);
    collect(-1, 0, 1);
    tests_run++;
    if (obs_q.size() != exp_q.size()) begin fails++; $display("FAIL poke_count: got %0d beats, expected %0d", obs_q.size(), exp_q.size()); end
    for (int k = 0; k < obs_q.size() && k < exp_q.size(); k++) begin
      tests_run++;
      if (obs_q[k] !== exp_q[k]) begin fails++; $display("FAIL poke_beat%0d: got %h, expected %h", k, obs_q[k], exp_q[k]); end
    end
    for (int k = 0; k < 4; k++) begin
      if (busy || out_valid) extra++;
      @(negedge clk);
    end
    tests_run++; if (extra != 0) begin fails++; $display("FAIL poke_queued: got %0d active cycles after done, expected 0", extra); end
  endtask

  task automatic test_reset_mid_hold();
    int n = 0;
    int active = 0;
    fill_bank_random();
    do_start(0, 31);
    out_ready = 1'b0;
    while (!out_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    tests_run++; if (out_valid !== 1) begin fails++; $display("FAIL rst_hold_reach: got out_valid %b, expected 1", out_valid); end
    #2 rst_n = 1'b0;
    #1;
    tests_run++; if (out_valid !== 0) begin fails++; $display("FAIL rst_hold_valid: got %b, expected 0", out_valid); end
    tests_run++; if (busy !== 0)      begin fails++; $display("FAIL rst_hold_busy: got %b, expected 0", busy); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (busy || out_valid || done) active++;
    end
    tests_run++; if (active != 0)     begin fails++; $display("FAIL rst_hold_idle: got %0d active cycles, expected 0", active); end
    build_exp(3, 6);
    do_start(3, 6);
    collect(-1, 0, 0);
    tests_run++;
    if (obs_q.size() != 4) begin fails++; $display("FAIL rst_restart_count: got %0d beats, expected 4", obs_q.size()); end
    for (int k = 0; k < obs_q.size() && k < exp_q.size(); k++) begin
      tests_run++;
      if (obs_q[k] !== exp_q[k]) begin fails++; $display("FAIL rst_restart_beat%0d: got %h, expected %h", k, obs_q[k], exp_q[k]); end
    end
  endtask

  task automatic test_random();
    int f, l;
    for (int r = 0; r < 6; r++) begin
      fill_bank_random();
      f = $urandom_range(0, NREG - 1);
      l = $urandom_range(f, NREG - 1);
      build_exp(f, l);
      do_start(f, l);
      collect(-1, 0, 1);
      tests_run++;
      if (obs_q.size() != exp_q.size()) begin
        fails++; $display("FAIL rand%0d_count: got %0d beats, expected %0d (range %0d..%0d)", r, obs_q.size(), exp_q.size(), f, l);
      end
      for (int k = 0; k < obs_q.size() && k < exp_q.size(); k++) begin
        tests_run++;
        if (obs_q[k] !== exp_q[k]) begin fails++; $display("FAIL rand%0d_beat%0d: got %h, expected %h", r, k, obs_q[k], exp_q[k]); end
      end
      tests_run++;
      if (done_cnt != 1) begin fails++; $display("FAIL rand%0d_done: got %0d pulses, expected 1", r, done_cnt); end
      tests_run++;
      if (stable_bad != 0) begin fails++; $display("FAIL rand%0d_stable: got %0d changes, expected 0", r, stable_bad); end
    end
  endtask

  // ---------------- main sequence / report ----------------
  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    abort     = 1'b0;
    out_ready = 1'b0;
    first_reg = '0;
    last_reg  = '0;
    fill_bank_ramp();
    repeat (2) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_full_range();
    test_single();
    test_stall();
    test_range_err();
    test_abort();
    test_start_during_dump();
    test_reset_mid_hold();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
